fdc_sector_xfer: RTL and testbench
==================================

FDC_SECTOR_XFER -- requirements
Module: fdc_sector_xfer

Interface
REQ-001 Parameter NUM_DRIVES, default 2: drives served, 1..4; DW = max(1, clog2(NUM_DRIVES)).
REQ-002 Parameter MAX_N, default 2: largest sector size code; buffer depth is 128<<MAX_N bytes.
REQ-003 Parameter OVR_CYCLES, default 4096: CPU service timeout in clocks, >=2.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; begins a transfer when busy=0.
REQ-007 dir  in  1  sampled at start; 0 = read (disk->CPU), 1 = write (CPU->disk).
REQ-008 drive / head / cyl / sect / eot / n_code  in  DW / 1 / 7 / 8 / 8 / 3  command fields, sampled at start.
REQ-009 tc  in  1  terminal count pulse.
REQ-010 cpu_rd, cpu_wr  in  1  one-cycle byte strobes; cpu_din in 8; cpu_dout out 8.
REQ-011 rqm  out  1  CPU byte transfer pending; busy out 1; done out 1 (one-cycle pulse).
REQ-012 st_err  out  3  {overrun, not_found, wp}, valid from done until next start.
REQ-013 res_sect  out  8  last sector attempted.
REQ-014 dsk_req  out  1  level sector request; dsk_wr out 1; dsk_drive out NUM_DRIVES one-hot; dsk_chs out 16 = {head, cyl, sect}.
REQ-015 dsk_ack, dsk_err  in  1  host completion pulse, with error qualifier.
REQ-016 dsk_din in 8, dsk_din_vld in 1 (fill byte); dsk_dout out 8, dsk_dout_rd in 1 (drain strobe); dsk_wp in NUM_DRIVES.

Function
REQ-017 Sector size S = 128 << min(n_code, MAX_N); the byte counter is BUF_AW+1 bits wide.
REQ-018 States: IDLE, FILL, CPU_RD, CPU_WR, COMMIT, NEXT, FINISH.
REQ-019 IDLE: start pulse latches all fields, busy=1 next cycle, st_err cleared. Read start -> FILL. Write start with dsk_wp[drive]=1 -> FINISH with wp=1 and no dsk_req. Other write starts -> CPU_WR.
REQ-020 FILL: dsk_req=1, dsk_wr=0, and dsk_chs/dsk_drive are driven. Each dsk_din_vld writes buf[cnt] and increments cnt. Bytes after cnt=S are ignored.
REQ-021 FILL exit: dsk_ack with dsk_err=1 -> FINISH with not_found=1. dsk_ack with dsk_err=0 -> CPU_RD with rd pointer 0. dsk_req drops in the same cycle the state leaves FILL.
REQ-022 CPU_RD: rqm=1 while pointer<S. Each cpu_rd updates cpu_dout=buf[pointer] on the next edge and increments the pointer. When the pointer reaches S -> NEXT.
REQ-023 CPU_WR: rqm=1 while cnt<S. Each cpu_wr writes cpu_din to buf[cnt]. When cnt reaches S -> COMMIT.
REQ-024 COMMIT: dsk_req=1, dsk_wr=1. Each dsk_dout_rd advances the drain pointer, and dsk_dout presents buf[pointer] combinationally. dsk_ack -> NEXT, or -> FINISH with not_found if dsk_err=1.
REQ-025 NEXT: res_sect=sect. If sect==eot -> FINISH. Otherwise sect increments mod 256, counters clear, and the state goes to FILL or CPU_WR by dir.
REQ-026 tc in CPU_RD or CPU_WR: remaining bytes are discarded, the partial write sector is not committed, and the state goes to FINISH with no error.
REQ-027 tc in FILL or COMMIT is ignored.
REQ-028 tc and a CPU strobe in the same cycle: the strobe is honoured first, then tc is applied.
REQ-029 Overrun: a timer runs while rqm=1, clears on each accepted CPU strobe, and is held at 0 while rqm=0. Reaching OVR_CYCLES -> FINISH with overrun=1.
REQ-030 FINISH: one cycle. done=1, busy=0 on the next edge, rqm=0, then IDLE.
REQ-031 start while busy=1 is ignored. cpu_rd/cpu_wr while rqm=0 have no effect, and cpu_dout holds its value.
REQ-032 dsk_ack outside FILL/COMMIT is ignored. dsk_din_vld and dsk_ack in the same cycle: the byte is written before the state exits.

Reset
REQ-033 rst_n low, at any time including mid-sector: state=IDLE, busy=0, rqm=0, done=0, st_err=0, res_sect=0, cpu_dout=8'h00, dsk_req=0, dsk_wr=0, dsk_drive=0, dsk_chs=0, all counters and the timer 0.
REQ-034 Buffer contents are not reset. The first cycle after deassertion accepts start.

Verification
REQ-035 Read, n_code=2, sect=3, eot=4: host fills 512 bytes of pattern i then acks, repeats for sector 4. CPU reads 1024 bytes -> data matches, dsk_chs sect 3 then 4, done with st_err=0, res_sect=4.
REQ-036 Write with dsk_wp[1]=1, drive=1 -> done within 2 cycles of start, st_err=3'b001, dsk_req never high.
REQ-037 Write, n_code=0: CPU writes 128 bytes -> dsk_req=1, dsk_wr=1. Host drains 128 bytes matching the input, then acks -> done.
REQ-038 Read where the CPU stops after 10 bytes -> done exactly OVR_CYCLES cycles after the 10th strobe, st_err=3'b100.
REQ-039 Read with dsk_ack+dsk_err -> not_found=1. Repeat, asserting tc after 5 CPU bytes, and separately pulling rst_n low mid-FILL -> tc gives done with no error; reset drops dsk_req asynchronously and the next start succeeds.
REQ-040 sect=255, eot=0, two-sector read -> dsk_chs sect 255 then 0, res_sect=0.

Source files
------------

// File: rtl/fdc_sector_xfer.sv
// Floppy sector transfer engine: moves whole sectors between a disk host port and a
// CPU byte port through one sector buffer, walking sect..eot with tc and overrun handling.
module fdc_sector_xfer #(
  parameter int NUM_DRIVES = 2,
  parameter int MAX_N      = 2,
  parameter int OVR_CYCLES = 4096,
  localparam int DW = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [DW-1:0]         drive,
  input  logic                  head,
  input  logic [6:0]            cyl,
  input  logic [7:0]            sect,
  input  logic [7:0]            eot,
  input  logic [2:0]            n_code,
  input  logic                  tc,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  rqm,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            st_err,
  output logic [7:0]            res_sect,
  output logic                  dsk_req,
  output logic                  dsk_wr,
  output logic [NUM_DRIVES-1:0] dsk_drive,
  output logic [15:0]           dsk_chs,
  input  logic                  dsk_ack,
  input  logic                  dsk_err,
  input  logic [7:0]            dsk_din,
  input  logic                  dsk_din_vld,
  output logic [7:0]            dsk_dout,
  input  logic                  dsk_dout_rd,
  input  logic [NUM_DRIVES-1:0] dsk_wp
);

  localparam int BUF_AW = 7 + MAX_N;
  localparam int DEPTH  = 128 << MAX_N;
  localparam int CW     = BUF_AW + 1;
  localparam int TW     = $clog2(OVR_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_CPU_RD, S_CPU_WR, S_COMMIT, S_NEXT, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic [DW-1:0]   drive_q, drive_d;
  logic            head_q, head_d;
  logic [6:0]      cyl_q, cyl_d;
  logic [7:0]      sect_q, sect_d;
  logic [7:0]      eot_q, eot_d;
  logic [2:0]      ncode_q, ncode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      cpu_dout_q, cpu_dout_d;
  logic [2:0]      st_err_q, st_err_d;
  logic [7:0]      res_sect_q, res_sect_d;

  logic [7:0]      buf_mem [DEPTH];
  logic            buf_we;
  logic [BUF_AW-1:0] buf_waddr;
  logic [7:0]      buf_wdata;
  logic [7:0]      rd_byte;

  logic [CW-1:0]   sect_size;
  logic            wp_sel;
  logic [NUM_DRIVES-1:0] drive_oh;
  logic            rd_acc, wr_acc, ovr_hit;

  // Size code is clipped to MAX_N when latched, so the shift always fits the counter.
  assign sect_size = CW'(128) << ncode_q;
  assign rd_byte   = buf_mem[ptr_q[BUF_AW-1:0]];

  assign rqm     = (state_q == S_CPU_RD && ptr_q < sect_size) ||
                   (state_q == S_CPU_WR && cnt_q < sect_size);
  assign rd_acc  = (state_q == S_CPU_RD) && rqm && cpu_rd;
  assign wr_acc  = (state_q == S_CPU_WR) && rqm && cpu_wr;
  assign ovr_hit = rqm && !rd_acc && !wr_acc && (timer_q == TW'(OVR_CYCLES - 1));

  always_comb begin
    wp_sel   = 1'b0;
    drive_oh = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (drive == DW'(i))   wp_sel      = dsk_wp[i];
      if (drive_q == DW'(i)) drive_oh[i] = 1'b1;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign dsk_req   = (state_q == S_FILL) || (state_q == S_COMMIT);
  assign dsk_wr    = (state_q == S_COMMIT);
  assign dsk_drive = dsk_req ? drive_oh : '0;
  assign dsk_chs   = dsk_req ? {head_q, cyl_q, sect_q} : 16'h0000;
  assign dsk_dout  = rd_byte;
  assign cpu_dout  = cpu_dout_q;
  assign st_err    = st_err_q;
  assign res_sect  = res_sect_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    drive_d    = drive_q;
    head_d     = head_q;
    cyl_d      = cyl_q;
    sect_d     = sect_q;
    eot_d      = eot_q;
    ncode_d    = ncode_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    cpu_dout_d = cpu_dout_q;
    st_err_d   = st_err_q;
    res_sect_d = res_sect_q;
    buf_we     = 1'b0;
    buf_waddr  = cnt_q[BUF_AW-1:0];
    buf_wdata  = dsk_din;
    timer_d    = (rqm && !rd_acc && !wr_acc) ? timer_q + TW'(1) : '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d    = dir;
          drive_d  = drive;
          head_d   = head;
          cyl_d    = cyl;
          sect_d   = sect;
          eot_d    = eot;
          ncode_d  = (n_code > 3'(MAX_N)) ? 3'(MAX_N) : n_code;
          cnt_d    = '0;
          ptr_d    = '0;
          st_err_d = 3'b000;
          if (!dir)       state_d = S_FILL;
          else if (wp_sel) begin
            state_d  = S_FINISH;
            st_err_d = 3'b001;
          end else        state_d = S_CPU_WR;
        end
      end

      S_FILL: begin
        if (dsk_din_vld && cnt_q < sect_size) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
        if (dsk_ack) begin
          if (dsk_err) begin
            state_d     = S_FINISH;
            st_err_d[1] = 1'b1;
          end else begin
            state_d = S_CPU_RD;
            ptr_d   = '0;
          end
        end
      end

      S_CPU_RD: begin
        if (rd_acc) begin
          cpu_dout_d = rd_byte;
          ptr_d      = ptr_q + CW'(1);
        end
        // A strobe in the same cycle as tc is taken before the transfer is cut short.
        if (tc)                       state_d = S_FINISH;
        else if (ptr_d >= sect_size)  state_d = S_NEXT;
        else if (ovr_hit) begin
          state_d     = S_FINISH;
          st_err_d[2] = 1'b1;
        end
      end

      S_CPU_WR: begin
        if (wr_acc) begin
          buf_we    = 1'b1;
          buf_wdata = cpu_din;
          cnt_d     = cnt_q + CW'(1);
        end
        if (tc)                       state_d = S_FINISH;
        else if (cnt_d >= sect_size) begin
          state_d = S_COMMIT;
          ptr_d   = '0;
        end else if (ovr_hit) begin
          state_d     = S_FINISH;
          st_err_d[2] = 1'b1;
        end
      end

      S_COMMIT: begin
        if (dsk_dout_rd && ptr_q < sect_size) ptr_d = ptr_q + CW'(1);
        if (dsk_ack) begin
          if (dsk_err) begin
            state_d     = S_FINISH;
            st_err_d[1] = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        res_sect_d = sect_q;
        if (sect_q == eot_q) begin
          state_d = S_FINISH;
        end else begin
          sect_d  = sect_q + 8'd1;
          cnt_d   = '0;
          ptr_d   = '0;
          state_d = dir_q ? S_CPU_WR : S_FILL;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      drive_q    <= '0;
      head_q     <= 1'b0;
      cyl_q      <= 7'd0;
      sect_q     <= 8'd0;
      eot_q      <= 8'd0;
      ncode_q    <= 3'd0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      timer_q    <= '0;
      cpu_dout_q <= 8'h00;
      st_err_q   <= 3'b000;
      res_sect_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      drive_q    <= drive_d;
      head_q     <= head_d;
      cyl_q      <= cyl_d;
      sect_q     <= sect_d;
      eot_q      <= eot_d;
      ncode_q    <= ncode_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      cpu_dout_q <= cpu_dout_d;
      st_err_q   <= st_err_d;
      res_sect_q <= res_sect_d;
    end
  end

  // NOTE: the sector buffer has no reset; every byte is written before it is read back.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[buf_waddr] <= buf_wdata;
  end

endmodule

// File: tb/tb_fdc_sector_xfer.sv
// Self-checking bench for fdc_sector_xfer: start-decision table, directed corner
// sequences and randomized transfers checked against a sector-level reference model.
module tb_fdc_sector_xfer;

  localparam int ND    = 2;
  localparam int MAXN  = 2;
  localparam int OVR   = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 0, dir = 0, head = 0, tc = 0, cpu_rd = 0, cpu_wr = 0;
  logic [0:0] drive = '0;
  logic [6:0] cyl = '0;
  logic [7:0] sect = '0, eot = '0, cpu_din = '0, dsk_din = '0;
  logic [2:0] n_code = '0;
  logic dsk_ack = 0, dsk_err = 0, dsk_din_vld = 0, dsk_dout_rd = 0;
  logic [ND-1:0] dsk_wp = '0;
  logic [7:0] cpu_dout, res_sect, dsk_dout;
  logic rqm, busy, done, dsk_req, dsk_wr;
  logic [2:0] st_err;
  logic [ND-1:0] dsk_drive;
  logic [15:0] dsk_chs;

  int errors = 0;
  int checks = 0;
  bit abort = 0;
  bit req_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wq[$];

  fdc_sector_xfer #(.NUM_DRIVES(ND), .MAX_N(MAXN), .OVR_CYCLES(OVR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .drive(drive), .head(head),
    .cyl(cyl), .sect(sect), .eot(eot), .n_code(n_code), .tc(tc), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .rqm(rqm), .busy(busy),
    .done(done), .st_err(st_err), .res_sect(res_sect), .dsk_req(dsk_req),
    .dsk_wr(dsk_wr), .dsk_drive(dsk_drive), .dsk_chs(dsk_chs), .dsk_ack(dsk_ack),
    .dsk_err(dsk_err), .dsk_din(dsk_din), .dsk_din_vld(dsk_din_vld),
    .dsk_dout(dsk_dout), .dsk_dout_rd(dsk_dout_rd), .dsk_wp(dsk_wp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic [0:0] drv;
    logic [1:0] wp;
    logic       busy, req, wr, rqm, done;
    logic [1:0] ddrive;
    logic [2:0] err;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // One clock: outputs are sampled 1ns after the edge, then all pulse inputs drop.
  task automatic step();
    @(posedge clk);
    #1;
    start = 0; tc = 0; cpu_rd = 0; cpu_wr = 0; dsk_ack = 0; dsk_err = 0;
    dsk_din_vld = 0; dsk_dout_rd = 0;
    if (dsk_req) req_seen = 1;
  endtask

  task automatic issue_start(input logic d, input logic [0:0] drv, input logic h,
                             input logic [6:0] c, input logic [7:0] s, input logic [7:0] e,
                             input logic [2:0] n);
    dir = d; drive = drv; head = h; cyl = c; sect = s; eot = e; n_code = n;
    start = 1;
    step();
  endtask

  task automatic wait_req();
    for (int k = 0; k < 50 && !dsk_req; k++) step();
    if (!dsk_req) begin check("req_timeout", dsk_req, 1); abort = 1; end
  endtask

  task automatic wait_rqm();
    for (int k = 0; k < 50 && !rqm; k++) step();
    if (!rqm) begin check("rqm_timeout", rqm, 1); abort = 1; end
  endtask

  task automatic wait_done(input int bound, output int nd);
    nd = 0;
    while (!done && nd < bound) begin step(); nd++; end
    check("done_seen", done, 1);
  endtask

  function automatic int sect_bytes(input logic [2:0] n);
    return 128 << ((int'(n) > MAXN) ? MAXN : int'(n));
  endfunction

  // Host side of one read sector: check the request, stream nb bytes, then ack.
  task automatic fill_sector(input int nb, input logic [0:0] drv, input logic h,
                             input logic [6:0] c, input logic [7:0] s, input bit pat,
                             input logic err, input bit ack_last);
    logic [7:0] b;
    wait_req();
    if (abort) return;
    check("fill_wr", dsk_wr, 0);
    check("fill_chs", dsk_chs, {h, c, s});
    check("fill_drive", dsk_drive, 2'b01 << drv);
    for (int i = 0; i < nb; i++) begin
      b = pat ? 8'(i) : 8'($urandom);
      if (!err) exp_q.push_back(b);
      if ($urandom_range(3) == 0) step();
      dsk_din = b; dsk_din_vld = 1;
      if (ack_last && i == nb - 1) begin dsk_ack = 1; dsk_err = err; end
      step();
    end
    if (!ack_last) begin dsk_ack = 1; dsk_err = err; step(); end
  endtask

  task automatic cpu_read(input int nb);
    logic [7:0] e;
    for (int i = 0; i < nb && !abort; i++) begin
      if ($urandom_range(3) == 0) step();
      wait_rqm();
      if (abort) return;
      cpu_rd = 1;
      step();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check("rd_byte", cpu_dout, e);
    end
  endtask

  task automatic do_read(input logic [0:0] drv, input logic h, input logic [6:0] c,
                         input logic [7:0] s0, input logic [7:0] eot_v,
                         input logic [2:0] n, input bit pat);
    int sz, nd;
    logic [7:0] s;
    sz = sect_bytes(n);
    exp_q.delete();
    issue_start(1'b0, drv, h, c, s0, eot_v, n);
    s = s0;
    forever begin
      fill_sector(sz, drv, h, c, s, pat, 1'b0, bit'($urandom_range(1)));
      cpu_read(sz);
      if (abort || s == eot_v) break;
      s = s + 8'd1;
    end
    if (abort) return;
    wait_done(8, nd);
    check("rd_st_err", st_err, 3'b000);
    check("rd_res_sect", res_sect, eot_v);
    step();
    check("rd_idle", busy, 0);
  endtask

  task automatic do_write(input logic [0:0] drv, input logic h, input logic [6:0] c,
                          input logic [7:0] s0, input logic [7:0] eot_v,
                          input logic [2:0] n);
    int sz, nd;
    logic [7:0] s, b, e;
    sz = sect_bytes(n);
    wq.delete();
    issue_start(1'b1, drv, h, c, s0, eot_v, n);
    s = s0;
    forever begin
      for (int i = 0; i < sz && !abort; i++) begin
        if ($urandom_range(3) == 0) step();
        wait_rqm();
        if (!abort) begin
          b = 8'($urandom);
          wq.push_back(b);
          cpu_din = b; cpu_wr = 1;
          step();
        end
      end
      if (abort) return;
      wait_req();
      if (abort) return;
      check("commit_wr", dsk_wr, 1);
      check("commit_chs", dsk_chs, {h, c, s});
      check("commit_drive", dsk_drive, 2'b01 << drv);
      for (int i = 0; i < sz; i++) begin
        if ($urandom_range(3) == 0) step();
        e = (wq.size() > 0) ? wq.pop_front() : 8'h00;
        check("drain_byte", dsk_dout, e);
        dsk_dout_rd = 1;
        step();
      end
      dsk_ack = 1;
      step();
      if (s == eot_v) break;
      s = s + 8'd1;
    end
    wait_done(8, nd);
    check("wr_st_err", st_err, 3'b000);
    check("wr_res_sect", res_sect, eot_v);
    step();
    check("wr_idle", busy, 0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req", dsk_req, 0);
    check("rst_rqm", rqm, 0);
    check("rst_done", done, 0);
    @(negedge clk) rst_n = 1;
  endtask

  initial begin
    int nd;
    //            dir drv wp     busy req wr rqm done ddrive err
    vt[0] = '{1'b0, 1'b0, 2'b00, 1, 1, 0, 0, 0, 2'b01, 3'b000};
    vt[1] = '{1'b0, 1'b1, 2'b11, 1, 1, 0, 0, 0, 2'b10, 3'b000};
    vt[2] = '{1'b1, 1'b0, 2'b00, 1, 0, 0, 1, 0, 2'b00, 3'b000};
    vt[3] = '{1'b1, 1'b1, 2'b10, 1, 0, 0, 0, 1, 2'b00, 3'b001};
    vt[4] = '{1'b1, 1'b0, 2'b10, 1, 0, 0, 1, 0, 2'b00, 3'b000};
    vt[5] = '{1'b1, 1'b1, 2'b01, 1, 0, 0, 1, 0, 2'b00, 3'b000};
    vt[6] = '{1'b1, 1'b0, 2'b01, 1, 0, 0, 0, 1, 2'b00, 3'b001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_rqm", rqm, 0);
    check("reset_done", done, 0);
    check("reset_st_err", st_err, 0);
    check("reset_res_sect", res_sect, 0);
    check("reset_cpu_dout", cpu_dout, 0);
    check("reset_dsk_req", dsk_req, 0);
    check("reset_dsk_wr", dsk_wr, 0);
    check("reset_dsk_drive", dsk_drive, 0);
    check("reset_dsk_chs", dsk_chs, 0);
    @(negedge clk) rst_n = 1;

    // Outcome of a start for each direction / drive / write-protect combination
    for (int i = 0; i < 7; i++) begin
      dsk_wp = vt[i].wp;
      issue_start(vt[i].dir, vt[i].drv, 1'b0, 7'd1, 8'd7, 8'd7, 3'd0);
      check("vec_busy", busy, vt[i].busy);
      check("vec_req", dsk_req, vt[i].req);
      check("vec_wr", dsk_wr, vt[i].wr);
      check("vec_rqm", rqm, vt[i].rqm);
      check("vec_done", done, vt[i].done);
      check("vec_drive", dsk_drive, vt[i].ddrive);
      check("vec_st_err", st_err, vt[i].err);
      pulse_reset();
    end
    dsk_wp = '0;

    // Two 512-byte sectors, sector 3 then 4, with a counting pattern
    do_read(1'b0, 1'b1, 7'd5, 8'd3, 8'd4, 3'd2, 1'b1);

    // Write-protected drive 1: finishes at once, never requests the disk
    dsk_wp = 2'b10;
    req_seen = 0;
    issue_start(1'b1, 1'b1, 1'b0, 7'd0, 8'd1, 8'd1, 3'd0);
    wait_done(2, nd);
    check("wp_latency_le1", nd <= 1, 1);
    check("wp_st_err", st_err, 3'b001);
    check("wp_no_req", req_seen, 0);
    step();
    dsk_wp = '0;

    // Single 128-byte write sector
    do_write(1'b0, 1'b0, 7'd1, 8'd12, 8'd12, 3'd0);

    // Overrun after 10 CPU bytes
    exp_q.delete();
    issue_start(1'b0, 1'b0, 1'b0, 7'd2, 8'd9, 8'd9, 3'd0);
    fill_sector(128, 1'b0, 1'b0, 7'd2, 8'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wait_rqm();
      cpu_rd = 1;
      step();
      check("ovr_byte", cpu_dout, exp_q.pop_front());
    end
    nd = 0;
    while (!done && nd < OVR + 20) begin step(); nd++; end
    check("ovr_latency", nd, OVR);
    check("ovr_st_err", st_err, 3'b100);
    step();
    cpu_rd = 1;
    step();
    check("cpu_dout_hold", cpu_dout, 8'd9);

    // Sector not found; a second start and a tc during FILL are both ignored
    exp_q.delete();
    issue_start(1'b0, 1'b0, 1'b0, 7'd4, 8'd20, 8'd21, 3'd0);
    start = 1; sect = 8'd50; tc = 1;
    step();
    check("start_ignored", dsk_chs[7:0], 8'd20);
    check("tc_fill_ignored", dsk_req, 1);
    fill_sector(128, 1'b0, 1'b0, 7'd4, 8'd20, 1'b0, 1'b1, 1'b0);
    wait_done(4, nd);
    check("nf_st_err", st_err, 3'b010);
    step();

    // tc after 5 CPU bytes of a two-sector read
    exp_q.delete();
    issue_start(1'b0, 1'b1, 1'b1, 7'd3, 8'd30, 8'd31, 3'd0);
    fill_sector(128, 1'b1, 1'b1, 7'd3, 8'd30, 1'b1, 1'b0, 1'b1);
    cpu_read(5);
    tc = 1;
    step();
    check("tc_done", done, 1);
    check("tc_st_err", st_err, 3'b000);
    step();
    check("tc_idle", busy, 0);

    // tc together with a CPU read strobe: byte delivered, then finish
    exp_q.delete();
    issue_start(1'b0, 1'b0, 1'b0, 7'd3, 8'd40, 8'd40, 3'd0);
    fill_sector(128, 1'b0, 1'b0, 7'd3, 8'd40, 1'b1, 1'b0, 1'b0);
    cpu_read(5);
    wait_rqm();
    cpu_rd = 1; tc = 1;
    step();
    check("tc_strobe_byte", cpu_dout, 8'd5);
    check("tc_strobe_done", done, 1);
    step();

    // tc in a partial write sector: nothing committed
    req_seen = 0;
    issue_start(1'b1, 1'b0, 1'b0, 7'd6, 8'd70, 8'd70, 3'd0);
    for (int i = 0; i < 3; i++) begin cpu_din = 8'(i); cpu_wr = 1; step(); end
    tc = 1;
    step();
    check("tc_wr_done", done, 1);
    check("tc_wr_st_err", st_err, 3'b000);
    check("tc_wr_no_req", req_seen, 0);
    step();

    // Reset in the middle of FILL, then a fresh transfer
    issue_start(1'b0, 1'b1, 1'b0, 7'd5, 8'd60, 8'd60, 3'd0);
    for (int i = 0; i < 3; i++) begin dsk_din = 8'(i); dsk_din_vld = 1; step(); end
    #2 rst_n = 0;
    #1;
    check("midfill_rst_req", dsk_req, 0);
    check("midfill_rst_busy", busy, 0);
    check("midfill_rst_chs", dsk_chs, 0);
    check("midfill_rst_drive", dsk_drive, 0);
    @(negedge clk) rst_n = 1;
    do_read(1'b1, 1'b0, 7'd5, 8'd61, 8'd61, 3'd0, 1'b0);

    // Sector number wraps from 255 to 0
    do_read(1'b0, 1'b0, 7'd0, 8'd255, 8'd0, 3'd0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 6 && !abort; t++) begin
      logic       rd_dir;
      logic [0:0] rdrv;
      logic [2:0] rn;
      logic [7:0] rs, re;
      rd_dir = 1'($urandom_range(1));
      rdrv   = 1'($urandom_range(1));
      rn     = 3'($urandom_range(3));
      rs     = 8'($urandom);
      re     = rs + 8'($urandom_range(1));
      if (rd_dir) do_write(rdrv, 1'($urandom), 7'($urandom), rs, re, rn);
      else        do_read(rdrv, 1'($urandom), 7'($urandom), rs, re, rn, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    checks++;
    errors++;
    $display("FAIL watchdog: cycle limit reached, got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
